time_bcd_counter: RTL

//  Real-time HH:MM:SS source for the 6-digit 7-segment display path.
//  - Prescales clk to a 1 s tick and keeps time as six packed BCD digits.
//  - Start/stop and minute/hour set are driven from push-buttons.
//  - Output drives the digit-mux FSM directly, with no glue logic.

---
 rtl/time_bcd_counter_if.sv | 23 ++
 rtl/time_bcd_counter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/time_bcd_counter_if.sv
// Button and display bundle for time_bcd_counter: push-button levels in,
// packed BCD time and status out.
interface time_bcd_counter_if;
   logic        start_stop;
   logic        clear;
   logic        inc_min;
   logic        inc_hour;
   logic        lap;
   logic [23:0] digits;
   logic        tick;
   logic        running;
   logic        lap_active;

   modport master (
      output start_stop, clear, inc_min, inc_hour, lap,
      input  digits, tick, running, lap_active
   );

   modport slave (
      input  start_stop, clear, inc_min, inc_hour, lap,
      output digits, tick, running, lap_active
   );
endinterface

// File: rtl/time_bcd_counter.sv
// HH:MM:SS real-time counter in packed BCD with start/stop, clear and set buttons.
// Optional lap-hold display freeze is built when LAP_HOLD_EN is defined.
module time_bcd_counter #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input logic               clk,
   input logic               reset,
   time_bcd_counter_if.slave bus
);

   localparam int unsigned      PRE_W    = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   typedef enum logic {ST_STOP, ST_RUN} state_t;

   typedef struct packed {
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
   } bcd_time_t;

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   bcd_time_t        time_q, time_d;
   logic             tick_q, tick_d;
   logic [3:0]       btn, prev_q;
   logic             ss_ev, clr_ev, min_ev, hour_ev;

   function automatic logic [7:0] inc_mod60(input logic [7:0] v);
      if (v[3:0] != 4'd9)      return {v[7:4], v[3:0] + 4'd1};
      else if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
      else                     return 8'h00;
   endfunction

   function automatic logic [7:0] inc_mod24(input logic [7:0] v);
      if (v == 8'h23)          return 8'h00;
      else if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
      else                     return {v[7:4] + 4'd1, 4'd0};
   endfunction

   function automatic bcd_time_t add_second(input bcd_time_t t);
      bcd_time_t r;
      r    = t;
      r.ss = inc_mod60(t.ss);
      if (t.ss == 8'h59) begin
         r.mm = inc_mod60(t.mm);
         if (t.mm == 8'h59) r.hh = inc_mod24(t.hh);
      end
      return r;
   endfunction

   assign btn = {bus.start_stop, bus.clear, bus.inc_min, bus.inc_hour};
   assign {ss_ev, clr_ev, min_ev, hour_ev} = btn & ~prev_q;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      pre_d   = pre_q;
      time_d  = time_q;
      tick_d  = 1'b0;

      if (ss_ev) state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;

      // clear overrides counting and setting but leaves the state toggle above intact
      if (clr_ev) begin
         pre_d  = '0;
         time_d = '0;
      end else if (state_q == ST_RUN) begin
         if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            time_d = add_second(time_q);
            tick_d = 1'b1;
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end else begin
         if (min_ev) begin
            time_d.mm = inc_mod60(time_q.mm);
            time_d.ss = 8'h00;
         end
         if (hour_ev) time_d.hh = inc_mod24(time_q.hh);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         state_q <= ST_STOP;
         pre_q   <= '0;
         time_q  <= '0;
         tick_q  <= 1'b0;
         prev_q  <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         time_q  <= time_d;
         tick_q  <= tick_d;
         prev_q  <= btn;
      end
   end

   assign bus.tick    = tick_q;
   assign bus.running = (state_q == ST_RUN);

`ifdef LAP_HOLD_EN
   logic        lap_prev_q, lap_ev, lap_q, lap_d;
   bcd_time_t   hold_q, hold_d;
   logic [23:0] digits_q;

   assign lap_ev = bus.lap & ~lap_prev_q;

   always_comb begin
      lap_d  = lap_q;
      hold_d = hold_q;
      if (clr_ev || (ss_ev && state_q == ST_RUN)) begin
         lap_d = 1'b0;
      end else if (lap_ev && state_q == ST_RUN) begin
         lap_d = ~lap_q;
         if (!lap_q) hold_d = time_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         lap_prev_q <= 1'b0;
         lap_q      <= 1'b0;
         hold_q     <= '0;
         digits_q   <= '0;
      end else begin
         lap_prev_q <= bus.lap;
         lap_q      <= lap_d;
         hold_q     <= hold_d;
         digits_q   <= lap_d ? hold_d : time_d;
      end
   end

   assign bus.digits     = digits_q;
   assign bus.lap_active = lap_q;
`else
   logic unused_lap;
   assign unused_lap     = bus.lap;
   assign bus.digits     = time_q;
   assign bus.lap_active = 1'b0;
`endif

endmodule
